// File: rtl/follower_pkg.sv
// -----------------------------------------------------------------------------
// follower_pkg
// Shared types and constants for the line-follower command path.
//   state_t        : controller state (IDLE / IN_TRANSIT)
//   CMD_STOP/GO    : opcode values found in cmd[7:6]
//   STATION_PREFIX : ID[7:6] value marking a real station ID
//   station_match  : true when an ID is a valid station equal to dest
// -----------------------------------------------------------------------------
package follower_pkg;

    typedef enum logic [0:0] {
        IDLE       = 1'b0,
        IN_TRANSIT = 1'b1
    } state_t;

    localparam logic [1:0] CMD_STOP       = 2'b00;
    localparam logic [1:0] CMD_GO         = 2'b01;
    localparam logic [1:0] STATION_PREFIX = 2'b00;

    // Barcode IDs with a non-zero prefix are noise and never match a station.
    function automatic logic station_match(input logic [7:0] id,
                                           input logic [5:0] dest);
        return (id[7:6] == STATION_PREFIX) && (id[5:0] == dest);
    endfunction

endpackage

// File: rtl/buzz_gen.sv
// -----------------------------------------------------------------------------
// buzz_gen
// Square-wave piezo driver. While en is high a counter runs 0..BUZZ_HALF-1 and
// buzz toggles each time it wraps, giving a period of 2*BUZZ_HALF clocks.
// With en low the counter and buzz are forced to 0 on the next edge.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : run the buzzer
//   buzz       : buzzer drive (registered)
//   buzz_n     : complement of buzz (registered, resets to 1)
// -----------------------------------------------------------------------------
module buzz_gen #(
    parameter int BUZZ_HALF = 6250
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic buzz,
    output logic buzz_n
);

    localparam int CW = (BUZZ_HALF > 2) ? $clog2(BUZZ_HALF) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BUZZ_HALF - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] cnt_r;
    logic          buzz_r;
    logic          buzz_n_r;
    logic          wrap_s;

    assign wrap_s = en && (cnt_r == CNT_LAST);

    // Half-period counter: runs only while enabled, restarts from 0 otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (!en) begin
            cnt_r <= '0;
        end else if (wrap_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // Toggle flop pair; buzz_n is kept as its own flop so both pins are glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buzz_r   <= 1'b0;
            buzz_n_r <= 1'b1;
        end else if (!en) begin
            buzz_r   <= 1'b0;
            buzz_n_r <= 1'b1;
        end else if (wrap_s) begin
            buzz_r   <= ~buzz_r;
            buzz_n_r <= buzz_r;
        end else begin
            buzz_r   <= buzz_r;
            buzz_n_r <= buzz_n_r;
        end
    end

    assign buzz   = buzz_r;
    assign buzz_n = buzz_n_r;

endmodule

// File: rtl/station_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// station_cmd_ctrl
// Command/destination controller. GO commands latch a 6-bit destination and
// put the robot in transit; a matching barcode station ID or a STOP command
// ends the transit. While in transit and blocked, the buzzer sounds.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   cmd         : UART command byte, [7:6] opcode, [5:0] destination
//   cmd_rdy     : cmd valid (level, held until clr_cmd_rdy)
//   clr_cmd_rdy : one-cycle pulse consuming cmd (same cycle as sampled)
//   ID          : barcode station ID, valid only when ID[7:6]==2'b00
//   ID_vld      : ID valid (level, held until clr_ID_vld)
//   clr_ID_vld  : one-cycle pulse consuming ID (same cycle as sampled)
//   OK2Move     : high when no obstacle ahead
//   in_transit  : registered, robot has an active destination
//   go          : in_transit & OK2Move
//   buzz/buzz_n : piezo drive and its complement
// -----------------------------------------------------------------------------
module station_cmd_ctrl
    import follower_pkg::*;
#(
    parameter int BUZZ_HALF = 6250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] cmd,
    input  logic       cmd_rdy,
    output logic       clr_cmd_rdy,
    input  logic [7:0] ID,
    input  logic       ID_vld,
    output logic       clr_ID_vld,
    input  logic       OK2Move,
    output logic       in_transit,
    output logic       go,
    output logic       buzz,
    output logic       buzz_n
);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [5:0] dest_r;
    logic [5:0] dest_nxt_s;
    logic       in_transit_r;
    logic       clr_cmd_s;
    logic       clr_id_s;
    logic [1:0] cmd_op_s;
    logic       id_hit_s;
    logic       buzz_en_s;

    assign cmd_op_s = cmd[7:6];
    assign id_hit_s = station_match(ID, dest_r);

    // State, destination and in_transit registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            dest_r       <= 6'h00;
            in_transit_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            dest_r       <= dest_nxt_s;
            in_transit_r <= (state_nxt_s == IN_TRANSIT);
        end
    end

    // Next-state and consume-pulse logic; a pending command always wins over
    // a pending ID so that only one valid is cleared per cycle.
    always_comb begin
        state_nxt_s = state_r;
        dest_nxt_s  = dest_r;
        clr_cmd_s   = 1'b0;
        clr_id_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (cmd_rdy) begin
                    clr_cmd_s = 1'b1;
                    if (cmd_op_s == CMD_GO) begin
                        dest_nxt_s  = cmd[5:0];
                        state_nxt_s = IN_TRANSIT;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else if (ID_vld) begin
                    clr_id_s = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            IN_TRANSIT: begin
                if (cmd_rdy) begin
                    clr_cmd_s = 1'b1;
                    case (cmd_op_s)
                        CMD_GO: begin
                            dest_nxt_s  = cmd[5:0];
                            state_nxt_s = IN_TRANSIT;
                        end
                        CMD_STOP: begin
                            state_nxt_s = IDLE;
                        end
                        default: begin
                            state_nxt_s = IN_TRANSIT;
                        end
                    endcase
                end else if (ID_vld) begin
                    clr_id_s = 1'b1;
                    if (id_hit_s) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = IN_TRANSIT;
                    end
                end else begin
                    state_nxt_s = IN_TRANSIT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    assign clr_cmd_rdy = clr_cmd_s;
    assign clr_ID_vld  = clr_id_s;
    assign in_transit  = in_transit_r;
    assign go          = in_transit_r & OK2Move;
    assign buzz_en_s   = in_transit_r & ~OK2Move;

    buzz_gen #(
        .BUZZ_HALF(BUZZ_HALF)
    ) u_buzz_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (buzz_en_s),
        .buzz  (buzz),
        .buzz_n(buzz_n)
    );

endmodule

// File: tb/tb_station_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_station_cmd_ctrl
// Directed scenarios followed by randomized traffic, checked cycle by cycle
// against a behavioural model of the controller and buzzer.
// -----------------------------------------------------------------------------
module tb_station_cmd_ctrl;

    localparam int BH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] cmd = 8'h00;
    logic       cmd_rdy = 1'b0;
    logic       clr_cmd_rdy;
    logic [7:0] ID = 8'h00;
    logic       ID_vld = 1'b0;
    logic       clr_ID_vld;
    logic       OK2Move = 1'b1;
    logic       in_transit;
    logic       go;
    logic       buzz;
    logic       buzz_n;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: travelling flag, destination, and consecutive blocked-edge count.
    bit         m_transit = 1'b0;
    logic [5:0] m_dest = 6'h00;
    int         m_run = 0;

    station_cmd_ctrl #(.BUZZ_HALF(BH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd        (cmd),
        .cmd_rdy    (cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .ID         (ID),
        .ID_vld     (ID_vld),
        .clr_ID_vld (clr_ID_vld),
        .OK2Move    (OK2Move),
        .in_transit (in_transit),
        .go         (go),
        .buzz       (buzz),
        .buzz_n     (buzz_n)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: check Mealy outputs mid-cycle, advance model, check registered outputs.
    task automatic cycle();
        logic e_ccr;
        logic e_civ;
        @(negedge clk);
        e_ccr = cmd_rdy;
        e_civ = ID_vld & ~cmd_rdy;
        check_val("clr_cmd_rdy", 32'(clr_cmd_rdy), 32'(e_ccr));
        check_val("clr_ID_vld", 32'(clr_ID_vld), 32'(e_civ));
        check_val("go", 32'(go), 32'(m_transit & OK2Move));
        if (m_transit && !OK2Move) m_run = m_run + 1;
        else m_run = 0;
        if (cmd_rdy) begin
            if (cmd[7:6] == 2'b01) begin
                m_transit = 1'b1;
                m_dest    = cmd[5:0];
            end else if (cmd[7:6] == 2'b00) begin
                m_transit = 1'b0;
            end
        end else if (ID_vld && m_transit && ID[7:6] == 2'b00 && ID[5:0] == m_dest) begin
            m_transit = 1'b0;
        end
        @(posedge clk);
        #1;
        check_val("in_transit", 32'(in_transit), 32'(m_transit));
        check_val("buzz", 32'(buzz), 32'((m_run / BH) % 2));
        check_val("buzz_n", 32'(buzz_n), 32'(1 - ((m_run / BH) % 2)));
        if (e_ccr) cmd_rdy = 1'b0;
        if (e_civ) ID_vld = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] c);
        cmd     = c;
        cmd_rdy = 1'b1;
        cycle();
    endtask

    task automatic send_id(input logic [7:0] i);
        ID     = i;
        ID_vld = 1'b1;
        cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_in_transit"}, 32'(in_transit), 32'd0);
        check_val({tag, "_go"}, 32'(go), 32'd0);
        check_val({tag, "_buzz"}, 32'(buzz), 32'd0);
        check_val({tag, "_buzz_n"}, 32'(buzz_n), 32'd1);
        check_val({tag, "_clr_cmd"}, 32'(clr_cmd_rdy), 32'd0);
        check_val({tag, "_clr_id"}, 32'(clr_ID_vld), 32'd0);
    endtask

    initial begin
        logic [1:0] op;
        int         r;

        // Reset held
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // GO to 5 then matching ID
        send_cmd(8'h45);
        check_val("go45_transit", 32'(in_transit), 32'd1);
        check_val("go45_go", 32'(go), 32'd1);
        send_id(8'h05);
        check_val("match05_stop", 32'(in_transit), 32'd0);

        // Non-matching and invalid-prefix IDs
        send_cmd(8'h45);
        send_id(8'h03);
        check_val("nomatch03", 32'(in_transit), 32'd1);
        send_id(8'h45);
        check_val("badprefix45", 32'(in_transit), 32'd1);

        // Retarget to 7
        send_cmd(8'h47);
        send_id(8'h05);
        check_val("retarget_old", 32'(in_transit), 32'd1);
        send_id(8'h07);
        check_val("retarget_new", 32'(in_transit), 32'd0);

        // STOP mid-transit, ignored opcode
        send_cmd(8'h45);
        send_cmd(8'hC5);
        check_val("ignored_op", 32'(in_transit), 32'd1);
        send_cmd(8'h00);
        check_val("stop", 32'(in_transit), 32'd0);

        // Simultaneous STOP and matching ID
        send_cmd(8'h45);
        cmd     = 8'h00;
        cmd_rdy = 1'b1;
        ID      = 8'h05;
        ID_vld  = 1'b1;
        cycle();
        check_val("simul_idle", 32'(in_transit), 32'd0);
        check_val("simul_id_pending", 32'(ID_vld), 32'd1);
        cycle();
        check_val("simul_id_late", 32'(in_transit), 32'd0);

        // Match while blocked still stops
        send_cmd(8'h45);
        OK2Move = 1'b0;
        send_id(8'h05);
        check_val("blocked_match", 32'(in_transit), 32'd0);
        OK2Move = 1'b1;
        cycle();

        // Buzzer timing
        send_cmd(8'h45);
        OK2Move = 1'b0;
        repeat (3) cycle();
        check_val("buzz_before_first", 32'(buzz), 32'd0);
        cycle();
        check_val("buzz_first_toggle", 32'(buzz), 32'd1);
        repeat (8) cycle();
        OK2Move = 1'b1;
        cycle();
        check_val("buzz_release", 32'(buzz), 32'd0);

        // Asynchronous reset mid-transit while blocked
        OK2Move = 1'b0;
        repeat (6) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        m_transit = 1'b0;
        m_dest    = 6'h00;
        m_run     = 0;
        @(negedge clk);
        #1;
        rst_n   = 1'b1;
        OK2Move = 1'b1;
        @(posedge clk);
        #1;

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            if (!cmd_rdy && $urandom_range(0, 5) == 0) begin
                r = $urandom_range(0, 7);
                if (r < 4) op = 2'b01;
                else if (r < 6) op = 2'b00;
                else op = 2'($urandom_range(2, 3));
                cmd     = {op, 6'($urandom_range(0, 7))};
                cmd_rdy = 1'b1;
            end
            if (!ID_vld && $urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 4) == 0) ID = {2'($urandom_range(1, 3)), 6'($urandom_range(0, 7))};
                else ID = {2'b00, 6'($urandom_range(0, 7))};
                ID_vld = 1'b1;
            end
            if ($urandom_range(0, 9) == 0) OK2Move = ~OK2Move;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
